// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (Moore, mem_ready-qualified strobes).
// Define MULTICYCLE_ADDI_EN to add the ADDI_EXEC/ADDI_WB path for opcode 001000.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       instr_done
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXECUTE,
    S_R_WB,
    S_BRANCH,
    S_JUMP
`ifdef MULTICYCLE_ADDI_EN
    ,
    S_ADDI_EXEC,
    S_ADDI_WB
`endif
  } state_e;

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    instr_done    = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):     state_d = S_MEM_ADDR;
          (opcode == OP_RTYPE):  state_d = S_EXECUTE;
          (opcode == OP_BEQ):    state_d = S_BRANCH;
          (opcode == OP_J):      state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          (opcode == OP_ADDI):   state_d = S_ADDI_EXEC;
`endif
          default: begin
            // Unknown opcodes retire here as a nop.
            state_d    = S_FETCH;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef MULTICYCLE_ADDI_EN
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode over several cycles and drives every datapath enable.
- It is the producer of the 2-bit ALUOp that the ALU-control decoder consumes: 00 = add, 01 = subtract, 10 = use funct field.
- Memory accesses use a ready handshake, so variable-latency memory can stall the FSM.

Parameters:
- STATE_W, 4, width of the state register.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  synchronous active-low reset
- opcode  in  6  instr[31:26], sampled from IR in DECODE
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  writeback source: 1 = MDR
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- alu_op  out  2  ALUOp to ALU control
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- reg_write  out  1  register file write
- reg_dst  out  1  1 = rd, 0 = rt
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction

Behaviour:
- Reset: rstn low at a clk edge sets state to IDLE. All outputs are 0 while in IDLE, and the reset value of every output is 0.
- IDLE moves to FETCH on the next edge, unconditionally. Reset asserted in any state, including mid-stall, returns to IDLE. No partial write is issued after that edge.
- Outputs are decoded combinationally from state (Moore), except where marked as qualified by mem_ready.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: 100011 (lw) or 101011 (sw) -> MEM_ADDR; 000000 -> EXECUTE; 000100 -> BRANCH; 000010 -> JUMP.
  - Any other opcode goes to FETCH, with instr_done=1 (treated as a nop).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw goes to MEM_READ; sw goes to MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Goes to FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready=1, then goes to FETCH. instr_done equals mem_ready.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
- Any output not listed for a state is 0 in that state.
- Unused state encodings go to IDLE.
- opcode is only sampled in DECODE and MEM_ADDR. The controller relies on IR holding its value outside FETCH.
- Cycle counts with mem_ready tied to 1: lw 5, sw 4, R-type 4, beq 3, j 3.

Optional Feature:
- Macro: MULTICYCLE_ADDI_EN.
- Defined:
  - Opcode 001000 in DECODE goes to ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_EXEC goes to ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
  - ADDI_WB goes to FETCH.
- Undefined: 001000 is treated as an unknown opcode (DECODE -> FETCH with instr_done=1), and the ADDI states do not exist.

Test Plan:
- Reset, mem_ready=1:
  - Hold rstn=0 for 2 cycles, then release with opcode=000000.
  - All outputs are 0 during reset.
  - First cycle after release is IDLE; the next is FETCH with pc_write=ir_write=mem_read=1.
- lw (opcode 100011), mem_ready=1:
  - State sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB.
  - instr_done pulses exactly once, in MEM_WB, with reg_write=1 and mem_to_reg=1.
- Fetch stall, mem_ready=0 for 3 cycles then 1:
  - FETCH is held 4 cycles.
  - pc_write and ir_write are 0 for the first 3 cycles and 1 only on the 4th.
- Opcode sweep:
  - R-type (000000) shows alu_op=10 in EXECUTE.
  - beq (000100) shows alu_op=01 and pc_write_cond=1 for exactly 1 cycle.
  - j (000010) shows pc_source=10 and pc_write=1.
- sw (101011) with mem_ready=0 in MEM_WRITE, rstn dropped on the 2nd stall cycle:
  - Next state is IDLE with mem_write=0.
  - Normal FETCH resumes afterwards.
- opcode 001000:
  - With MULTICYCLE_ADDI_EN defined: 4-cycle instruction, reg_write=1 in ADDI_WB.
  - Without it: 2-cycle nop (FETCH, DECODE) with reg_write never 1.
